// File: rtl/div_issue_ctrl_pkg.sv
// Shared FSM encoding and defaults for the EX-stage divider issue controller.
package div_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2,
    DIV_CLR  = 2'd3
  } div_state_e;

  localparam int DEFAULT_DW         = 32;
  localparam int DEFAULT_CLR_CYCLES = 2;

  // When both decode lines are high the op is treated as signed DIV.
  function automatic logic op_is_signed(input logic inst_div, input logic inst_divu);
    return inst_div | (inst_div & inst_divu);
  endfunction

endpackage

// File: rtl/div_issue_ctrl.sv
// Issues DIV/DIVU to the iterative divider, stalls EX until the result lands, then writes HI/LO.
// Stall covers the issue cycle plus divider latency; DONE is held while EX is frozen elsewhere.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int DW         = DEFAULT_DW,
  parameter int CLR_CYCLES = DEFAULT_CLR_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_div_i,
  input  logic            inst_divu_i,
  input  logic [DW-1:0]   rs_i,
  input  logic [DW-1:0]   rt_i,
  input  logic            flush_i,
  input  logic            ex_stall_i,
  input  logic [2*DW-1:0] div_result_i,
  input  logic            div_ready_i,
  output logic            div_start_o,
  output logic            div_annul_o,
  output logic            div_signed_o,
  output logic [DW-1:0]   div_op1_o,
  output logic [DW-1:0]   div_op2_o,
  output logic            stallreq_o,
  output logic            hilo_we_o,
  output logic [DW-1:0]   hi_o,
  output logic [DW-1:0]   lo_o
);

  localparam int CW = $clog2(CLR_CYCLES + 1);

  div_state_e    state;
  logic [CW-1:0] clr_cnt;
  logic          op;

  assign op = inst_div_i | inst_divu_i;

  always_comb begin
    div_start_o = (state == DIV_BUSY) && !flush_i;
    div_annul_o = flush_i;
    hilo_we_o   = (state == DIV_DONE) && !flush_i;
    stallreq_o  = 1'b0;
    if (!flush_i) begin
      case (state)
        DIV_IDLE, DIV_CLR: stallreq_o = op;
        DIV_BUSY:          stallreq_o = 1'b1;
        default:           stallreq_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= DIV_IDLE;
      clr_cnt      <= '0;
      div_signed_o <= 1'b0;
      div_op1_o    <= '0;
      div_op2_o    <= '0;
      hi_o         <= '0;
      lo_o         <= '0;
    end else if (flush_i) begin
      // Only an op that reached the divider needs the drain window before re-issue.
      clr_cnt <= '0;
      state   <= (state == DIV_BUSY || state == DIV_CLR) ? DIV_CLR : DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (op) begin
            div_op1_o    <= rs_i;
            div_op2_o    <= rt_i;
            div_signed_o <= op_is_signed(inst_div_i, inst_divu_i);
            state        <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          if (div_ready_i) begin
            hi_o  <= div_result_i[2*DW-1:DW];
            lo_o  <= div_result_i[DW-1:0];
            state <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (!ex_stall_i) state <= DIV_IDLE;
        end
        DIV_CLR: begin
          if (clr_cnt == CW'(CLR_CYCLES - 1)) begin
            clr_cnt <= '0;
            state   <= DIV_IDLE;
          end else begin
            clr_cnt <= clr_cnt + CW'(1);
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural divider model plus scoreboard of expected {hi,lo}.
module tb_div_issue_ctrl;

  localparam int DW         = 32;
  localparam int CLR_CYCLES = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          inst_div = 1'b0, inst_divu = 1'b0, flush = 1'b0, ex_stall = 1'b0;
  logic [DW-1:0] rs = '0, rt = '0;
  logic [63:0]   div_result = '0;
  logic          div_ready = 1'b0;
  logic          div_start_o, div_annul_o, div_signed_o, stallreq_o, hilo_we_o;
  logic [DW-1:0] div_op1_o, div_op2_o, hi_o, lo_o;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];

  div_issue_ctrl #(.DW(DW), .CLR_CYCLES(CLR_CYCLES)) dut (
    .clk(clk), .rst(rst), .inst_div_i(inst_div), .inst_divu_i(inst_divu),
    .rs_i(rs), .rt_i(rt), .flush_i(flush), .ex_stall_i(ex_stall),
    .div_result_i(div_result), .div_ready_i(div_ready),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
    .div_op1_o(div_op1_o), .div_op2_o(div_op2_o), .stallreq_o(stallreq_o),
    .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Divider: ready in start-cycle 36 (4 for divisor 0); result from operands as held at finish.
  int m_st = 0, m_cnt = 0, m_tgt = 0;
  always @(posedge clk) begin
    if (rst || div_annul_o) begin
      m_st <= 0; m_cnt <= 0; div_ready <= 1'b0; div_result <= '0;
    end else begin
      case (m_st)
        0: if (div_start_o) begin
             m_cnt <= 1; m_tgt <= (div_op2_o == 0) ? 4 : 36; m_st <= 1;
           end
        1: begin
             m_cnt <= m_cnt + 1;
             if (m_cnt + 1 == m_tgt - 1) begin
               div_ready  <= 1'b1;
               div_result <= model_div(div_op1_o, div_op2_o, div_signed_o);
               m_st       <= 2;
             end
           end
        default: if (!div_start_o) begin m_st <= 0; div_ready <= 1'b0; end
      endcase
    end
  end

  task automatic drive(input logic r, input logic d, input logic du, input logic [31:0] a,
                       input logic [31:0] b, input logic fl, input logic st);
    @(negedge clk);
    rst = r; inst_div = d; inst_divu = du; rs = a; rt = b; flush = fl; ex_stall = st;
    #1;
  endtask

  task automatic run_op(input logic d, input logic du, input logic [31:0] a, input logic [31:0] b,
                        output int n_stall, output int n_we, output logic [63:0] got,
                        output logic hold_ok, output logic timed_out);
    n_stall = 0; n_we = 0; got = '0; hold_ok = 1'b1; timed_out = 1'b1;
    for (int c = 0; c < 100; c++) begin
      drive(0, d, du, a, b, 0, 0);
      if (stallreq_o) n_stall++;
      if (div_start_o && (div_signed_o !== d || div_op1_o !== a || div_op2_o !== b)) hold_ok = 1'b0;
      if (hilo_we_o) begin n_we++; got = {hi_o, lo_o}; timed_out = 1'b0; break; end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    if (stallreq_o) n_stall++;
    if (hilo_we_o) n_we++;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL reset_stallreq got=%b want=0", stallreq_o); end
    total++; if ({div_start_o, div_annul_o, hilo_we_o} !== 3'b000) begin bad++; $display("FAIL reset_ctrl got=%b want=000", {div_start_o, div_annul_o, hilo_we_o}); end
    total++; if ({hi_o, lo_o} !== 64'd0) begin bad++; $display("FAIL reset_hilo got=%h want=0", {hi_o, lo_o}); end
    total++; if ({div_signed_o, div_op1_o, div_op2_o} !== 65'd0) begin bad++; $display("FAIL reset_ops got=%h want=0", {div_signed_o, div_op1_o, div_op2_o}); end
  endtask

  task automatic test_divu_basic();
    int ns, nw; logic [63:0] got, e; logic ok, to;
    exp_q.push_back({32'd2, 32'd14});
    run_op(0, 1, 32'd100, 32'd7, ns, nw, got, ok, to);
    e = exp_q.pop_front();
    total++; if (to !== 1'b0) begin bad++; $display("FAIL divu_timeout got=%b want=0", to); end
    total++; if (got !== e) begin bad++; $display("FAIL divu_result got=%h want=%h", got, e); end
    total++; if (ns !== 37) begin bad++; $display("FAIL divu_stall_cycles got=%0d want=37", ns); end
    total++; if (nw !== 1) begin bad++; $display("FAIL divu_we_cycles got=%0d want=1", nw); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL divu_hold got=%b want=1", ok); end
  endtask

  task automatic test_div_signed();
    int ns, nw; logic [63:0] got, e; logic ok, to;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(1, 0, 32'hFFFF_FFF9, 32'd2, ns, nw, got, ok, to);
    e = exp_q.pop_front();
    total++; if (got !== e || to !== 1'b0) begin bad++; $display("FAIL div_signed_result got=%h want=%h", got, e); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL div_signed_held got=%b want=1", ok); end
    total++; if (ns !== 37 || nw !== 1) begin bad++; $display("FAIL div_signed_cycles got=%0d/%0d want=37/1", ns, nw); end
  endtask

  task automatic test_div_both();
    int ns, nw; logic [63:0] got, e; logic ok, to;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFE});
    run_op(1, 1, 32'hFFFF_FFF7, 32'd4, ns, nw, got, ok, to);
    e = exp_q.pop_front();
    total++; if (got !== e || to !== 1'b0) begin bad++; $display("FAIL both_as_div got=%h want=%h", got, e); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL both_signed_held got=%b want=1", ok); end
  endtask

  task automatic test_div_by_zero();
    int ns, nw; logic [63:0] got, e; logic ok, to;
    exp_q.push_back(64'd0);
    run_op(0, 1, 32'd5, 32'd0, ns, nw, got, ok, to);
    e = exp_q.pop_front();
    total++; if (got !== e || to !== 1'b0) begin bad++; $display("FAIL zero_result got=%h want=%h", got, e); end
    total++; if (ns !== 5) begin bad++; $display("FAIL zero_stall_cycles got=%0d want=5", ns); end
    total++; if (nw !== 1) begin bad++; $display("FAIL zero_we_cycles got=%0d want=1", nw); end
  endtask

  task automatic test_flush_back_to_back();
    int n_start, gap, nw; logic side, seen; logic [63:0] got, e;
    drive(0, 0, 1, 32'd50, 32'd5, 0, 0);
    total++; if (stallreq_o !== 1'b1) begin bad++; $display("FAIL flush_issue_stall got=%b want=1", stallreq_o); end
    n_start = 0;
    for (int c = 0; c < 9; c++) begin
      drive(0, 0, 1, 32'd50, 32'd5, 0, 0);
      if (div_start_o) n_start++;
    end
    total++; if (n_start !== 9) begin bad++; $display("FAIL flush_busy_start got=%0d want=9", n_start); end
    drive(0, 0, 1, 32'd50, 32'd5, 1, 0);
    total++; if ({div_annul_o, div_start_o, stallreq_o, hilo_we_o} !== 4'b1000) begin
      bad++; $display("FAIL flush_cycle got=%b want=1000", {div_annul_o, div_start_o, stallreq_o, hilo_we_o});
    end
    exp_q.push_back({32'd0, 32'd3});
    gap = 0; side = 1'b0;
    for (int c = 0; c < 20; c++) begin
      drive(0, 0, 1, 32'd9, 32'd3, 0, 0);
      if (div_start_o) break;
      gap++;
      if (div_annul_o || hilo_we_o || !stallreq_o) side = 1'b1;
    end
    total++; if (gap !== CLR_CYCLES + 1) begin bad++; $display("FAIL flush_clr_wait got=%0d want=%0d", gap, CLR_CYCLES + 1); end
    total++; if (side !== 1'b0) begin bad++; $display("FAIL flush_wait_signals got=%b want=0", side); end
    seen = 1'b0; got = '0; nw = 0;
    for (int c = 0; c < 60; c++) begin
      drive(0, 0, 1, 32'd9, 32'd3, 0, 0);
      if (hilo_we_o) begin seen = 1'b1; nw++; got = {hi_o, lo_o}; break; end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    if (hilo_we_o) nw++;
    e = exp_q.pop_front();
    total++; if (got !== e || seen !== 1'b1) begin bad++; $display("FAIL flush_b2b_result got=%h want=%h", got, e); end
    total++; if (nw !== 1) begin bad++; $display("FAIL flush_b2b_we got=%0d want=1", nw); end
  endtask

  task automatic test_ex_stall();
    int n_hold; logic seen; logic [63:0] e;
    exp_q.push_back({32'd1, 32'd3});
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      drive(0, 0, 1, 32'd13, 32'd4, 0, 1);
      if (hilo_we_o) begin seen = 1'b1; break; end
    end
    e = exp_q.pop_front();
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL stall_timeout got=%b want=1", seen); end
    n_hold = ({hi_o, lo_o} === e) ? 1 : 0;
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 1, 32'd13, 32'd4, 0, (c < 2) ? 1'b1 : 1'b0);
      if (hilo_we_o && !stallreq_o && {hi_o, lo_o} === e) n_hold++;
    end
    total++; if (n_hold !== 4) begin bad++; $display("FAIL stall_hold_cycles got=%0d want=4", n_hold); end
    drive(0, 0, 0, 0, 0, 0, 0);
    total++; if ({hilo_we_o, stallreq_o, div_start_o} !== 3'b000) begin bad++; $display("FAIL stall_release got=%b want=000", {hilo_we_o, stallreq_o, div_start_o}); end
    total++; if ({hi_o, lo_o} !== e) begin bad++; $display("FAIL stall_hilo_kept got=%h want=%h", {hi_o, lo_o}, e); end
  endtask

  task automatic test_reset_mid();
    int ns, nw; logic [63:0] got, e; logic ok, to;
    for (int c = 0; c < 20; c++) drive(0, 0, 1, 32'd77, 32'd3, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    total++; if (div_start_o !== 1'b1) begin bad++; $display("FAIL rstmid_busy got=%b want=1", div_start_o); end
    drive(0, 0, 0, 0, 0, 0, 0);
    total++; if ({div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o, stallreq_o, hilo_we_o, hi_o, lo_o} !== '0) begin
      bad++; $display("FAIL rstmid_outputs got=%h want=0", {div_signed_o, div_op1_o, div_op2_o, hi_o, lo_o});
    end
    exp_q.push_back({32'd0, 32'd4});
    run_op(0, 1, 32'd8, 32'd2, ns, nw, got, ok, to);
    e = exp_q.pop_front();
    total++; if (got !== e || to !== 1'b0) begin bad++; $display("FAIL rstmid_next_result got=%h want=%h", got, e); end
    total++; if (ns !== 37 || nw !== 1) begin bad++; $display("FAIL rstmid_next_cycles got=%0d/%0d want=37/1", ns, nw); end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_div_signed();
    test_div_both();
    test_div_by_zero();
    test_flush_back_to_back();
    test_ex_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
